// File: rtl/sr_flag_arbiter_if.sv
// Handshake and status bundle between two SR-flag requesters and the arbiter.
interface sr_flag_arbiter_if #(
  parameter int NBITS = 8,
  parameter int IDXW  = 3
);
  logic             req_a;
  logic [1:0]       cmd_a;
  logic [IDXW-1:0]  idx_a;
  logic             gnt_a;
  logic             req_b;
  logic [1:0]       cmd_b;
  logic [IDXW-1:0]  idx_b;
  logic             gnt_b;
  logic [NBITS-1:0] q;
  logic [NBITS-1:0] qbar;
  logic             busy;
  logic             err;
  logic [3:0]       err_cnt;

  modport master (
    output req_a, cmd_a, idx_a,
    output req_b, cmd_b, idx_b,
    input  gnt_a, gnt_b,
    input  q, qbar, busy, err, err_cnt
  );

  modport slave (
    input  req_a, cmd_a, idx_a,
    input  req_b, cmd_b, idx_b,
    output gnt_a, gnt_b,
    output q, qbar, busy, err, err_cnt
  );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting two requesters set/reset access
// to a shared SR flag bank, one command per three cycles.
module sr_flag_arbiter #(
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  sr_flag_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    UPDATE = 2'd2
  } state_e;

  localparam logic [1:0] CMD_CLR = 2'b01;
  localparam logic [1:0] CMD_SET = 2'b10;
  localparam logic [1:0] CMD_ILL = 2'b11;

  state_e           state_q, state_d;
  logic             prio_b_q, prio_b_d;
  logic             win_q, win_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [NBITS-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             pick_b;
  logic [31:0]      idx_ext;
  logic             idx_ok;
  logic [NBITS-1:0] sel;
  logic [NBITS-1:0] q_upd;
  logic             bad;

  assign idx_ext = 32'(idx_q);
  assign idx_ok  = idx_ext < 32'(NBITS);

  // Out-of-range index or illegal command is rejected; bank untouched.
  always_comb begin
    sel   = '0;
    bad   = 1'b0;
    q_upd = q_q;
    for (int i = 0; i < NBITS; i++) begin
      sel[i] = (idx_ext == 32'(i));
    end
    unique case (1'b1)
      idx_ok && cmd_q == CMD_SET: q_upd = q_q | sel;
      idx_ok && cmd_q == CMD_CLR: q_upd = q_q & ~sel;
      !idx_ok || cmd_q == CMD_ILL: bad = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    prio_b_d = prio_b_q;
    win_d    = win_q;
    cmd_d    = cmd_q;
    idx_d    = idx_q;
    q_d      = q_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    pick_b   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          pick_b   = bus.req_b && (!bus.req_a || prio_b_q);
          win_d    = pick_b;
          prio_b_d = !pick_b;
          cmd_d    = pick_b ? bus.cmd_b : bus.cmd_a;
          idx_d    = pick_b ? bus.idx_b : bus.idx_a;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        state_d = UPDATE;
        q_d     = q_upd;
        err_d   = bad;
        if (bad && cnt_q != 4'hF) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prio_b_q <= 1'b0;
      win_q    <= 1'b0;
      cmd_q    <= '0;
      idx_q    <= '0;
      q_q      <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_b_q <= prio_b_d;
      win_q    <= win_d;
      cmd_q    <= cmd_d;
      idx_q    <= idx_d;
      q_q      <= q_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.gnt_a   = (state_q == GRANT) && !win_q;
  assign bus.gnt_b   = (state_q == GRANT) && win_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.q       = q_q;
  assign bus.qbar    = ~q_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = cnt_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter (NBITS=8, IDXW=4 so idx 9 is reachable).
module tb_sr_flag_arbiter;
  localparam int NBITS = 8;
  localparam int IDXW  = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  sr_flag_arbiter_if #(.NBITS(NBITS), .IDXW(IDXW)) bus ();

  sr_flag_arbiter #(.NBITS(NBITS), .IDXW(IDXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic r, input logic [1:0] c,
                       input logic [IDXW-1:0] i);
    bus.req_a = r;
    bus.cmd_a = c;
    bus.idx_a = i;
  endtask

  task automatic drv_b(input logic r, input logic [1:0] c,
                       input logic [IDXW-1:0] i);
    bus.req_b = r;
    bus.cmd_b = c;
    bus.idx_b = i;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    drv_b(1'b0, 2'b00, 4'd0);
    drv_a(1'b1, 2'b10, 4'd3);

    // Reset state, with a request already pending
    #12;
    chk("rst_q", 32'(bus.q), 32'h00);
    chk("rst_qbar", 32'(bus.qbar), 32'hFF);
    chk("rst_gnt_a", 32'(bus.gnt_a), 32'h0);
    chk("rst_gnt_b", 32'(bus.gnt_b), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_cnt", 32'(bus.err_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Set idx 3: first edge after release samples
    step();
    chk("s3_gnt_a", 32'(bus.gnt_a), 32'h1);
    chk("s3_gnt_b", 32'(bus.gnt_b), 32'h0);
    chk("s3_busy1", 32'(bus.busy), 32'h1);
    chk("s3_q_early", 32'(bus.q), 32'h00);
    drv_a(1'b0, 2'b00, 4'd0);
    step();
    chk("s3_q", 32'(bus.q), 32'h08);
    chk("s3_qbar", 32'(bus.qbar), 32'hF7);
    chk("s3_gnt_a_off", 32'(bus.gnt_a), 32'h0);
    chk("s3_busy2", 32'(bus.busy), 32'h1);
    chk("s3_err", 32'(bus.err), 32'h0);
    step();
    chk("s3_idle", 32'(bus.busy), 32'h0);
    chk("s3_hold", 32'(bus.q), 32'h08);

    // Reset again, B sets idx 3 so the pointer favours A
    rst_n = 1'b0;
    #1;
    chk("rst2_q", 32'(bus.q), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drv_b(1'b1, 2'b10, 4'd3);
    step();
    chk("b3_gnt_b", 32'(bus.gnt_b), 32'h1);
    drv_b(1'b0, 2'b00, 4'd0);
    step();
    chk("b3_q", 32'(bus.q), 32'h08);
    step();

    // Simultaneous requests: A first, then B
    drv_a(1'b1, 2'b01, 4'd3);
    drv_b(1'b1, 2'b10, 4'd0);
    step();
    chk("both_gnt_a", 32'(bus.gnt_a), 32'h1);
    chk("both_gnt_b0", 32'(bus.gnt_b), 32'h0);
    drv_a(1'b0, 2'b00, 4'd0);
    step();
    chk("both_q_a", 32'(bus.q), 32'h00);
    step();
    chk("both_nosample", 32'(bus.gnt_b), 32'h0);
    step();
    chk("both_gnt_b", 32'(bus.gnt_b), 32'h1);
    chk("both_gnt_a0", 32'(bus.gnt_a), 32'h0);
    drv_b(1'b0, 2'b00, 4'd0);
    step();
    chk("both_q_b", 32'(bus.q), 32'h01);
    step();

    // Continuous holds alternate A,B every 3 cycles
    drv_a(1'b1, 2'b00, 4'd5);
    drv_b(1'b1, 2'b00, 4'd6);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("rr_gnt_a", 32'(bus.gnt_a), 32'((k % 6) == 1));
      chk("rr_gnt_b", 32'(bus.gnt_b), 32'((k % 6) == 4));
    end
    drv_a(1'b0, 2'b00, 4'd0);
    drv_b(1'b0, 2'b00, 4'd0);
    chk("rr_q", 32'(bus.q), 32'h01);

    // Illegal command, then out-of-range index
    drv_a(1'b1, 2'b11, 4'd2);
    step();
    drv_a(1'b0, 2'b00, 4'd0);
    step();
    chk("ill_err", 32'(bus.err), 32'h1);
    chk("ill_q", 32'(bus.q), 32'h01);
    chk("ill_cnt", 32'(bus.err_cnt), 32'h1);
    step();
    chk("ill_err_pulse", 32'(bus.err), 32'h0);
    drv_b(1'b1, 2'b10, 4'd9);
    step();
    chk("oor_gnt_b", 32'(bus.gnt_b), 32'h1);
    drv_b(1'b0, 2'b00, 4'd0);
    step();
    chk("oor_err", 32'(bus.err), 32'h1);
    chk("oor_q", 32'(bus.q), 32'h01);
    chk("oor_cnt", 32'(bus.err_cnt), 32'h2);
    step();

    // 16 more rejects saturate the counter
    for (int n = 0; n < 16; n++) begin
      drv_a(1'b1, 2'b11, 4'd1);
      step();
      drv_a(1'b0, 2'b00, 4'd0);
      step();
      step();
    end
    chk("sat_cnt", 32'(bus.err_cnt), 32'hF);
    chk("sat_q", 32'(bus.q), 32'h01);

    // Reset mid-GRANT abandons the set of idx 7
    drv_a(1'b1, 2'b10, 4'd7);
    step();
    chk("mid_gnt_a", 32'(bus.gnt_a), 32'h1);
    #2;
    rst_n = 1'b0;
    drv_a(1'b0, 2'b00, 4'd0);
    #1;
    chk("mid_q", 32'(bus.q), 32'h00);
    chk("mid_gnt", 32'(bus.gnt_a), 32'h0);
    chk("mid_busy", 32'(bus.busy), 32'h0);
    chk("mid_cnt", 32'(bus.err_cnt), 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    chk("post_q", 32'(bus.q), 32'h00);
    chk("post_busy", 32'(bus.busy), 32'h0);
    step();
    chk("post_q2", 32'(bus.q), 32'h00);
    chk("post_gnt", 32'(bus.gnt_a | bus.gnt_b), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sr_flag_arbiter.md
SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

Interface
REQ-001 Parameter NBITS, default 8: number of SR flag bits in the shared bank.
REQ-002 Parameter IDXW, default 3: width of the bit-index fields.
REQ-003 Port clk  input  1: single clock; all state changes on posedge clk.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port req_a  input  1: requester A command request, level, held until granted.
REQ-006 Port cmd_a  input  2: A command: 00 hold, 01 reset bit, 10 set bit, 11 illegal.
REQ-007 Port idx_a  input  IDXW: A target bit index.
REQ-008 Port gnt_a  output  1: one-cycle grant pulse to A.
REQ-009 Ports req_b, cmd_b, idx_b, gnt_b: same directions, widths and meanings as the A ports, for requester B.
REQ-010 Port q  output  NBITS: flag bank state.
REQ-011 Port qbar  output  NBITS: bitwise complement of q, always.
REQ-012 Port busy  output  1: high whenever FSM is not IDLE.
REQ-013 Port err  output  1: one-cycle pulse flagging a rejected command.
REQ-014 Port err_cnt  output  4: saturating count of err pulses.

Function
REQ-015 FSM SHALL have states IDLE, GRANT, UPDATE and no others; every unused encoding SHALL return to IDLE.
REQ-016 IDLE: if req_a or req_b is high at an edge, the arbiter SHALL capture the winner's cmd/idx, go to GRANT, and assert the winner's gnt for exactly that GRANT cycle.
REQ-017 IDLE with no request SHALL remain IDLE; q SHALL hold.
REQ-018 Both requests in the same IDLE cycle: winner SHALL be the requester not granted last (round-robin pointer); the pointer SHALL be updated to the winner on each grant.
REQ-019 GRANT SHALL always go to UPDATE on the next edge; on that same edge the captured command SHALL be applied to q[idx].
REQ-020 Command 10 SHALL set q[idx]=1; command 01 SHALL set q[idx]=0; command 00 SHALL leave q unchanged.
REQ-021 Command 11 SHALL leave q unchanged, and never drive X. err SHALL be high for the UPDATE cycle.
REQ-022 idx >= NBITS SHALL leave q unchanged. err SHALL be high for the UPDATE cycle.
REQ-023 UPDATE SHALL always go to IDLE on the next edge; requests SHALL NOT be sampled in GRANT or UPDATE.
REQ-024 Throughput: at most one command per 3 cycles; req-sample-edge to q-update latency SHALL be 2 edges.
REQ-025 Requesters SHALL drop req on the edge at which gnt is seen high. A req still high when the FSM returns to IDLE SHALL be treated as a new request.
REQ-026 err_cnt SHALL increment on each err pulse and saturate at 15.
REQ-027 Only the addressed bit SHALL change; all other q bits SHALL hold.

Reset
REQ-028 rst_n low SHALL immediately, independent of clk, force: state IDLE, q=0, qbar=all ones, gnt_a=gnt_b=0, busy=0, err=0, err_cnt=0, round-robin pointer favouring A.
REQ-029 Reset asserted in GRANT or UPDATE SHALL abandon the captured command; q SHALL remain 0 after release.
REQ-030 First rising clk edge after rst_n rises SHALL be treated as a normal IDLE sample.

Verification
REQ-031 Reset; then req_a=1, cmd_a=10, idx_a=3 -> gnt_a high for 1 cycle; q=8'h08 two edges after sample; qbar=8'hF7; busy high 2 cycles.
REQ-032 q=8'h08; simultaneous req_a (01, idx 3) and req_b (10, idx 0) after reset -> A is granted first, q=8'h00; B is granted next, q=8'h01; gnt_a and gnt_b are never both high.
REQ-033 Both requesters hold req continuously -> grants alternate A,B,A,B, exactly 3 cycles apart.
REQ-034 cmd_a=11 idx 2 followed by cmd_b=10 idx 9 (NBITS=8, IDXW=4 build) -> q unchanged, two err pulses, err_cnt=2; 16 more illegal commands -> err_cnt=15.
REQ-035 rst_n pulled low mid-GRANT for a set of idx 7 -> q=0 immediately and after release; no gnt; state IDLE.
